mesh_switch_allocator: RTL and testbench
========================================

MESH_SWITCH_ALLOCATOR -- requirements
Module: mesh_switch_allocator

Interface
REQ-001 Parameter N_PORTS, default 5, meaning number of router ports in [c,n,e,s,w] order; index 0 = local core.
REQ-002 Parameter CNT_W, default 8, meaning width of each per-output grant counter.
REQ-003 Port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, meaning asynchronous, active-low reset.
REQ-005 Port i_output_req, input, [0:N_PORTS-1][0:N_PORTS-1], meaning per-input one-hot request for the [c,n,e,s,w] output, taken directly from that input's route calculator; all-zero = no request.
REQ-006 Port i_en, input, [0:N_PORTS-1], meaning per-output downstream ready (space/credit available this cycle).
REQ-007 Port o_output_grant, output, [0:N_PORTS-1][0:N_PORTS-1], meaning per-output one-hot select of the winning input, driving the crossbar.
REQ-008 Port o_input_grant, output, [0:N_PORTS-1], meaning per-input "flit leaves this cycle", used as the pop for that input buffer.
REQ-009 Port o_grant_count, output, [0:N_PORTS-1][CNT_W-1:0], meaning per-output count of granted transfers since reset, for performance monitoring.

Function
REQ-010 Each output j SHALL have an independent round-robin arbiter over the N_PORTS inputs that request j.
REQ-011 Grants SHALL be combinational from i_output_req, i_en and registered priority state: zero-cycle latency, one flit per output per cycle.
REQ-012 If i_en[j] is 0, o_output_grant[j] SHALL be all-zero and the priority state of output j SHALL NOT change.
REQ-013 Priority for output j SHALL start at input ptr[j] and search upward, wrapping modulo N_PORTS; the first requesting input wins.
REQ-014 On a cycle with a grant of input i on output j, ptr[j] SHALL become (i+1) mod N_PORTS at the next rising clk edge; otherwise ptr[j] SHALL hold.
REQ-015 o_input_grant[i] SHALL be the OR over j of o_output_grant[j][i].
REQ-016 If an input's request has more than one bit set, only its lowest-index set bit SHALL be considered; at most one output SHALL be granted per input per cycle.
REQ-017 Requests to the input's own direction (U-turn) SHALL NOT be filtered; they are arbitrated like any other.
REQ-018 An ungranted request SHALL be held by the requester; the allocator keeps no request memory beyond ptr.
REQ-019 o_grant_count[j] SHALL increment by 1 on every granted cycle of output j and SHALL wrap from all-ones to zero.
REQ-020 A round-robin arbiter SHALL grant a continuously requesting input within N_PORTS grants of its output (starvation bound).

Reset
REQ-021 Asserting reset_n low SHALL immediately set every ptr[j] to 0 and every o_grant_count[j] to 0, independent of clk.
REQ-022 During reset, grants SHALL still be computed combinationally from ptr = 0. The allocator SHALL NOT block traffic because of reset. Upstream buffers are empty in reset, so no grant is issued.
REQ-023 Reset asserted mid-traffic SHALL discard all priority history. The first grant after release SHALL favour input 0.

Structure
REQ-024 N_PORTS, the port index constants (C=0, N=1, E=2, S=3, W=4) and the one-hot request typedef SHALL live in the shared MESH package/config include.
REQ-025 The per-output arbiter SHALL be a sub-module, mesh_rr_arbiter, instantiated N_PORTS times. It holds ptr, the request/grant vectors, the enable input and the counter.
REQ-026 Expected implementation size is 120-400 lines of RTL including mesh_rr_arbiter.

Verification
REQ-027 Reset, then inputs 1,2,3 all request East (output 2) with i_en=all ones for 3 cycles -> output 2 grants input 1, then 2, then 3; o_grant_count[2]=3.
REQ-028 Inputs 0 and 4 request North, i_en[1]=0 for 2 cycles, then 1 -> no grants while disabled, ptr[1] unchanged, then input 0 granted, then input 4.
REQ-029 Input 0 requests Local, input 1 requests East, input 2 requests South in the same cycle -> three simultaneous grants; o_input_grant=5'b11100.
REQ-030 All 5 inputs continuously request West for 10 cycles -> grants rotate 0,1,2,3,4,0,...; no input waits more than 5 cycles.
REQ-031 Input 3 drives 5'b01100 -> only North granted to input 3; East shows no grant from input 3.
REQ-032 Advance ptr[2] to 3, then assert reset_n low asynchronously mid-cycle -> ptr and counters read 0 before the next edge; after release, inputs 0 and 3 requesting East -> input 0 wins.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh router definitions: port count, direction indices
// and the one-hot request type used by route calculators.
package mesh_pkg;

    localparam int N_PORTS = 5;

    localparam int PORT_C = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    typedef logic [0:N_PORTS-1] mesh_oh_t;

endpackage

// File: rtl/mesh_rr_arbiter.sv
// Round-robin arbiter for one switch output: rotating priority
// pointer, enable gating and a wrapping grant counter.
module mesh_rr_arbiter #(
    parameter int N     = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [0:N-1]     req_i,
    input  logic             en_i,
    output logic [0:N-1]     gnt_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    win;
    logic             found;

    // Search starts at ptr_q and wraps; first requester wins.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && en_i && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
                win        = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (found) begin
            ptr_d = (win == LAST) ? '0 : win + 1'b1;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mesh_switch_allocator.sv
// Mesh router switch allocator: one round-robin arbiter per output,
// one output per input per cycle, combinational grants.
module mesh_switch_allocator #(
    parameter int N_PORTS = mesh_pkg::N_PORTS,
    parameter int CNT_W   = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [0:N_PORTS-1][0:N_PORTS-1]      i_output_req,
    input  logic [0:N_PORTS-1]                   i_en,
    output logic [0:N_PORTS-1][0:N_PORTS-1]      o_output_grant,
    output logic [0:N_PORTS-1]                   o_input_grant,
    output logic [0:N_PORTS-1][CNT_W-1:0]        o_grant_count
);

    import mesh_pkg::*;

    logic [0:N_PORTS-1][0:N_PORTS-1] req_col;

    // Keep only the lowest-index request per input, transposed per output.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        req_col = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            hit = 1'b0;
            for (int j = 0; j < N_PORTS; j++) begin
                if (!hit && i_output_req[i][j]) begin
                    req_col[j][i] = 1'b1;
                    hit           = 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
        mesh_rr_arbiter #(
            .N     (N_PORTS),
            .CNT_W (CNT_W)
        ) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .req_i   (req_col[j]),
            .en_i    (i_en[j]),
            .gnt_o   (o_output_grant[j]),
            .cnt_o   (o_grant_count[j])
        );
    end

    always_comb begin
        o_input_grant = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                o_input_grant[i] = o_input_grant[i] | o_output_grant[j][i];
            end
        end
    end

endmodule

// File: tb/tb_mesh_switch_allocator.sv
// Directed-vector bench for the mesh switch allocator.
module tb_mesh_switch_allocator;

    import mesh_pkg::*;

    logic                clk;
    logic                reset_n;
    logic [0:4][0:4]     req;
    logic [0:4]          en;
    logic [0:4][0:4]     ogr;
    logic [0:4]          igr;
    logic [0:4][7:0]     cnt;

    int n_vec;
    int n_err;

    mesh_switch_allocator #(
        .N_PORTS (5),
        .CNT_W   (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_output_req   (req),
        .i_en           (en),
        .o_output_grant (ogr),
        .o_input_grant  (igr),
        .o_grant_count  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:4] e;
        int wt [5];
        int maxw;
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        req     = '0;
        en      = '1;
        #12;
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_gnt", 64'(ogr), 64'd0);
        reset_n = 1'b1;

        // Inputs 1,2,3 all to East
        req[1] = 5'b00100;
        req[2] = 5'b00100;
        req[3] = 5'b00100;
        #1;
        chk("east_g0", 64'(ogr[PORT_E]), 64'(5'b01000));
        step();
        chk("east_g1", 64'(ogr[PORT_E]), 64'(5'b00100));
        step();
        chk("east_g2", 64'(ogr[PORT_E]), 64'(5'b00010));
        step();
        chk("east_cnt", 64'(cnt[PORT_E]), 64'd3);
        req = '0;

        // North disabled for two cycles
        req[0] = 5'b01000;
        req[4] = 5'b01000;
        en     = 5'b10111;
        #1;
        chk("n_dis0", 64'(ogr[PORT_N]), 64'd0);
        chk("n_dis_ig", 64'(igr), 64'd0);
        step();
        chk("n_dis1", 64'(ogr[PORT_N]), 64'd0);
        step();
        en = '1;
        #1;
        chk("n_en0", 64'(ogr[PORT_N]), 64'(5'b10000));
        step();
        chk("n_en1", 64'(ogr[PORT_N]), 64'(5'b00001));
        step();
        chk("n_cnt", 64'(cnt[PORT_N]), 64'd2);
        req = '0;

        // Three parallel grants
        req[0] = 5'b10000;
        req[1] = 5'b00100;
        req[2] = 5'b00010;
        #1;
        chk("par_ig", 64'(igr), 64'(5'b11100));
        chk("par_c", 64'(ogr[PORT_C]), 64'(5'b10000));
        chk("par_e", 64'(ogr[PORT_E]), 64'(5'b01000));
        chk("par_s", 64'(ogr[PORT_S]), 64'(5'b00100));
        step();
        req = '0;

        // Multi-hot request: lowest index only
        req[3] = 5'b01100;
        #1;
        chk("mh_n", 64'(ogr[PORT_N]), 64'(5'b00010));
        chk("mh_e", 64'(ogr[PORT_E]), 64'd0);
        chk("mh_ig", 64'(igr), 64'(5'b00010));
        step();
        req = '0;

        // All inputs to West for 10 cycles
        for (int i = 0; i < 5; i++) begin
            req[i] = 5'b00001;
            wt[i]  = 0;
        end
        maxw = 0;
        #1;
        for (int k = 0; k < 10; k++) begin
            e = 5'b10000 >> (k % 5);
            chk($sformatf("w_rot%0d", k), 64'(ogr[PORT_W]), 64'(e));
            for (int i = 0; i < 5; i++) begin
                if (ogr[PORT_W][i]) wt[i] = 0;
                else wt[i]++;
                if (wt[i] > maxw) maxw = wt[i];
            end
            step();
        end
        chk("w_maxwait", 64'(maxw), 64'd4);
        chk("w_cnt", 64'(cnt[PORT_W]), 64'd10);
        req = '0;

        // Advance East pointer to 3, then reset mid-cycle
        req[2] = 5'b00100;
        #1;
        chk("adv_g", 64'(ogr[PORT_E]), 64'(5'b00100));
        step();
        req[2] = 5'b00100;
        req[3] = 5'b00100;
        #1;
        chk("pre_rst_g", 64'(ogr[PORT_E]), 64'(5'b00010));
        chk("pre_rst_cnt", 64'(cnt[PORT_E]), 64'd5);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(cnt), 64'd0);
        chk("mid_rst_g", 64'(ogr[PORT_E]), 64'(5'b00100));
        req     = '0;
        #1;
        reset_n = 1'b1;
        req[0]  = 5'b00100;
        req[3]  = 5'b00100;
        #1;
        chk("post_rst_g", 64'(ogr[PORT_E]), 64'(5'b10000));
        step();
        chk("post_rst_cnt", 64'(cnt[PORT_E]), 64'd1);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
